// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO: default geometry and the
// per-cycle operation encoding used to advance the pointers.
package sync_fifo_pkg;

  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_DATA_WIDTH = 32;

  // What the FIFO does on a given clock edge once Full/Empty gating is applied.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

  // Fold the accepted-write and accepted-read strobes into one operation code.
  function automatic fifo_op_e decode_op(input logic wr_acc, input logic rd_acc);
    fifo_op_e op;
    op = fifo_op_e'({rd_acc, wr_acc});
    return op;
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array: synchronous write port, registered read
// port. The read register is the FIFO's data_out and resets to zero; the
// storage array itself is never cleared.
module sync_fifo_mem #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Storage write: only accepted writes touch the array.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read: update only on an accepted read, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock FIFO with chip-select-gated write and read ports.
//
// Port semantics: a write is accepted on a rising edge when cs & wr_en & !Full,
// a read when cs & rd_en & !Empty. Requests that are not accepted are dropped
// silently with no state change. Read data appears on data_out one edge after
// the accepting edge and holds until the next accepted read.
//
// Pointers carry one extra wrap bit so that Full and Empty can be told apart
// when the address fields are equal.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  Full,
  output logic                  Empty
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]       r_wr_ptr;
  logic [ADDR_W:0]       r_rd_ptr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  fifo_op_e              w_op;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Flags come straight from the registered pointers.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                   (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

  // Gating by Full/Empty resolves the simultaneous cases: on Empty only the
  // write can land, on Full only the read can.
  assign w_wr_acc = cs & wr_en & ~w_full;
  assign w_rd_acc = cs & rd_en & ~w_empty;
  assign w_op     = decode_op(w_wr_acc, w_rd_acc);

  // Pointer advance; wrap modulo 2*FIFO_DEPTH falls out of the natural width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      case (w_op)
        OP_WR: r_wr_ptr <= r_wr_ptr + PTR_ONE;
        OP_RD: r_rd_ptr <= r_rd_ptr + PTR_ONE;
        OP_RW: begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
        default: begin
          r_wr_ptr <= r_wr_ptr;
          r_rd_ptr <= r_rd_ptr;
        end
      endcase
    end
  end

  sync_fifo_mem #(
    .DEPTH      (FIFO_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .i_wr_data (data_in),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .o_rd_data (w_rd_data)
  );

  assign data_out = w_rd_data;
  assign Full     = w_full;
  assign Empty    = w_empty;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo (depth 8, width 32): directed scenarios followed by a
// random traffic phase, all checked against a queue-based reference model.
module tb_sync_fifo;

  localparam int DEPTH = 8;
  localparam int W     = 32;

  logic         clk;
  logic         rst_n;
  logic         cs;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         Full;
  logic         Empty;

  // Reference model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_dout;

  int n_tests;
  int n_fail;

  sync_fifo #(
    .FIFO_DEPTH (DEPTH),
    .DATA_WIDTH (W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .Full     (Full),
    .Empty    (Empty)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the model.
  task automatic check_outputs(input string tag);
    check({tag, "_dout"},  data_out, exp_dout);
    check({tag, "_full"},  {{(W-1){1'b0}}, Full},  {{(W-1){1'b0}}, (exp_q.size() == DEPTH)});
    check({tag, "_empty"}, {{(W-1){1'b0}}, Empty}, {{(W-1){1'b0}}, (exp_q.size() == 0)});
  endtask

  // One clock of stimulus: drive at negedge, update model at posedge, check #1 later.
  task automatic do_cycle(input logic c, input logic w, input logic r, input logic [W-1:0] d);
    logic wr_acc;
    logic rd_acc;
    @(negedge clk);
    cs      = c;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    wr_acc = c && w && (exp_q.size() < DEPTH);
    rd_acc = c && r && (exp_q.size() > 0);
    if (rd_acc) exp_dout = exp_q.pop_front();
    if (wr_acc) exp_q.push_back(d);
    #1;
    check_outputs("cyc");
  endtask

  task automatic wr(input logic [W-1:0] d);
    do_cycle(1'b1, 1'b1, 1'b0, d);
  endtask

  task automatic rd();
    do_cycle(1'b1, 1'b0, 1'b1, '0);
  endtask

  task automatic go_idle();
    @(negedge clk);
    cs      = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
  endtask

  // Reset asserted between edges must clear everything at once.
  task automatic async_reset();
    go_idle();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_dout = '0;
    #1;
    check("rst_async_dout", data_out, '0);
    check("rst_async_empty", {{(W-1){1'b0}}, Empty}, 32'd1);
    check("rst_async_full",  {{(W-1){1'b0}}, Full},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    exp_dout = '0;
    rst_n    = 1'b0;
    cs       = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    data_in  = '0;
    #1;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Three writes, three reads in order
    wr(32'd1);
    wr(32'd100);
    wr(32'd1000);
    rd(); check("seq_rd0", data_out, 32'd1);
    rd(); check("seq_rd1", data_out, 32'd100);
    rd(); check("seq_rd2", data_out, 32'd1000);
    check("seq_empty", {{(W-1){1'b0}}, Empty}, 32'd1);

    // Interleaved write/read of powers of two
    for (int i = 0; i < 8; i++) begin
      wr(32'd1 << i);
      rd();
      check("intl_dout", data_out, 32'd1 << i);
      check("intl_empty", {{(W-1){1'b0}}, Empty}, 32'd1);
    end

    // Fill to Full, overflow attempt, drain
    for (int i = 0; i < 8; i++) wr(32'd1 << i);
    check("fill_full", {{(W-1){1'b0}}, Full}, 32'd1);
    wr(32'hDEAD);
    check("ovf_full", {{(W-1){1'b0}}, Full}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      rd();
      check("drain_dout", data_out, 32'd1 << i);
    end
    check("drain_empty", {{(W-1){1'b0}}, Empty}, 32'd1);

    // Read on empty holds data_out
    rd();
    check("rd_empty_hold", data_out, 32'd128);
    wr(32'd5);
    rd();
    check("after_empty_rd", data_out, 32'd5);

    // cs low ignores both requests
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'd7);
    check("cs0_empty", {{(W-1){1'b0}}, Empty}, 32'd1);
    do_cycle(1'b0, 1'b0, 1'b1, '0);
    check("cs0_rd_hold", data_out, 32'd5);

    // Simultaneous read/write in the middle, on empty and on full
    do_cycle(1'b1, 1'b1, 1'b1, 32'h11);
    wr(32'h22);
    do_cycle(1'b1, 1'b1, 1'b1, 32'h33);
    check("rw_mid", data_out, 32'h11);
    for (int i = 0; i < 7; i++) wr(32'h40 + i);
    do_cycle(1'b1, 1'b1, 1'b1, 32'hBAD);
    check("rw_full_dout", data_out, 32'h22);
    check("rw_full_flag", {{(W-1){1'b0}}, Full}, 32'd0);

    // Async reset mid-operation
    async_reset();
    wr(32'd1); wr(32'd2); wr(32'd3);
    async_reset();
    wr(32'd9);
    rd();
    check("post_rst_rd", data_out, 32'd9);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      do_cycle(($urandom_range(0, 9) != 0),
               ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 1) == 1),
               $urandom());
    end

    // Drain remaining entries
    while (exp_q.size() > 0) rd();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sync_fifo
